// File: rtl/nco_ctrl.sv
// nco_ctrl: byte-command front end that resets, loads and runs an NCO waveform table.
// Define NCO_CTRL_TIMEOUT_EN to abort a load that stalls in LOAD_WAIT for TIMEOUT_CYC cycles.
module nco_ctrl #(
  parameter int MAX_ADDR    = 6000,
  parameter int STROBE_MAX  = 520,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        nco_rst_n_o,
  output logic        nco_sys_en_o,
  output logic        nco_we_o,
  output logic [7:0]  nco_data_o,
  output logic [13:0] nco_freq_step_o,
  output logic        loaded_o,
  output logic        busy_o,
  output logic        err_o
);
  typedef enum logic [2:0] {IDLE, FREQ_LO, FREQ_HI, NRST, LOAD_WAIT, LOAD_HOLD} state_t;
  localparam int SW = $clog2(STROBE_MAX + 1);
  localparam int BW = $clog2(MAX_ADDR + 1);
  localparam logic [SW-1:0] S_LAST = SW'(STROBE_MAX);
  localparam logic [BW-1:0] B_LAST = BW'(MAX_ADDR - 1);
  localparam logic [13:0] F_MAX = 14'(MAX_ADDR);
  state_t state, state_nx;
  logic run, err_nx, acc, strobe, freq_ok, timeout, ncnt, nrst_q;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic [7:0] freq_lo;
  logic [13:0] freq_val;
  assign rx_ready_o = rst_n && (state inside {IDLE, FREQ_LO, FREQ_HI, LOAD_WAIT});
  assign acc = rx_valid_i && rx_ready_o;
  assign nco_we_o = state == LOAD_HOLD;
  assign nco_sys_en_o = nco_we_o || (run && loaded_o && state inside {IDLE, FREQ_LO, FREQ_HI});
  assign nco_rst_n_o = nrst_q && state != NRST;
  assign busy_o = state inside {NRST, LOAD_WAIT, LOAD_HOLD};
  assign strobe = nco_sys_en_o && scnt == S_LAST;
  assign freq_val = {rx_data_i[5:0], freq_lo};
  assign freq_ok = freq_val != 14'd0 && freq_val <= F_MAX;
`ifdef NCO_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt;
  assign timeout = tcnt == T_LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= state == LOAD_WAIT && !acc ? tcnt + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    err_nx = 1'b0;
    case (state)
      IDLE: if (acc) begin
        state_nx = rx_data_i == 8'h01 ? NRST : rx_data_i == 8'h02 ? FREQ_LO : IDLE;
        err_nx = rx_data_i == 8'h03 ? !loaded_o : !(rx_data_i inside {8'h01, 8'h02, 8'h04});
      end
      FREQ_LO: if (acc) state_nx = FREQ_HI;
      FREQ_HI: if (acc) begin
        state_nx = IDLE;
        err_nx = !freq_ok;
      end
      NRST: if (ncnt) state_nx = LOAD_WAIT;
      LOAD_WAIT: if (acc) state_nx = LOAD_HOLD;
        else if (timeout) begin
          state_nx = IDLE;
          err_nx = 1'b1;
        end
      LOAD_HOLD: if (strobe) state_nx = bcnt == B_LAST ? IDLE : LOAD_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // scnt mirrors the NCO's own strobe divider so hold lengths line up with its address steps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      loaded_o <= 1'b0;
      err_o <= 1'b0;
      nco_data_o <= 8'd0;
      nco_freq_step_o <= 14'd1;
      scnt <= '0;
      bcnt <= '0;
      ncnt <= 1'b0;
      nrst_q <= 1'b0;
      freq_lo <= 8'd0;
    end else begin
      err_o <= err_nx;
      nrst_q <= 1'b1;
      ncnt <= state == NRST && !ncnt;
      scnt <= state == NRST || strobe ? '0 : nco_sys_en_o ? scnt + 1'b1 : scnt;
      bcnt <= state == NRST ? '0 : state == LOAD_HOLD && strobe ? bcnt + 1'b1 : bcnt;
      if (state == IDLE && acc)
        run <= rx_data_i == 8'h03 ? loaded_o : rx_data_i == 8'h04 || rx_data_i == 8'h01 ? 1'b0 : run;
      if (state == IDLE && acc && rx_data_i == 8'h01) loaded_o <= 1'b0;
      else if (state == LOAD_HOLD && strobe && bcnt == B_LAST) loaded_o <= 1'b1;
      if (state == FREQ_LO && acc) freq_lo <= rx_data_i;
      if (state == FREQ_HI && acc && freq_ok) nco_freq_step_o <= freq_val;
      if (state == LOAD_WAIT && acc) nco_data_o <= rx_data_i;
    end
endmodule

// File: tb/tb_nco_ctrl.sv
// tb_nco_ctrl: directed and randomized checks of nco_ctrl against a queue-based model of
// the command protocol, table writes and frequency validation.
module tb_nco_ctrl;
  localparam int MA = 4, SM = 3, TO = 20;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic rx_ready, nco_rst_n, sys_en, we, loaded, busy, err;
  logic [7:0] data;
  logic [13:0] step;
  int checks = 0, passes = 0, fails = 0;
  int nlow = 0, last_nlow = 0, wlen = 0;
  logic [7:0] wdat = 8'd0;
  logic unstable = 1'b0;
  int wq_len[$];
  logic [7:0] wq_dat[$];
  logic [7:0] tbl[$];
  logic [13:0] exp_step = 14'd1;

  nco_ctrl #(.MAX_ADDR(MA), .STROBE_MAX(SM), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_ready_o(rx_ready), .nco_rst_n_o(nco_rst_n), .nco_sys_en_o(sys_en),
    .nco_we_o(we), .nco_data_o(data), .nco_freq_step_o(step),
    .loaded_o(loaded), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // Record NCO-reset low run lengths and each write burst (length, byte) as the NCO would see them.
  always @(negedge clk) begin
    if (!rst_n) begin
      nlow = 0;
      wlen = 0;
    end else begin
      if (!nco_rst_n) nlow++;
      else if (nlow > 0) begin
        last_nlow = nlow;
        nlow = 0;
      end
      if (we) begin
        if (wlen > 0 && data !== wdat) unstable = 1'b1;
        wdat = data;
        wlen++;
      end else if (wlen > 0) begin
        wq_len.push_back(wlen);
        wq_dat.push_back(wdat);
        wlen = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_wait", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {25'd0, rx_ready, nco_rst_n, sys_en, we, loaded, busy, err}, 32'd0);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
    chk({tag, "_step"}, {18'd0, step}, 32'd1);
  endtask

  task automatic load(input logic rnd, input string tag);
    int n = 0;
    tbl.delete();
    wq_len.delete();
    wq_dat.delete();
    unstable = 1'b0;
    send(8'h01);
    chk({tag, "_nrst"}, {27'd0, busy, nco_rst_n, sys_en, loaded, rx_ready}, 32'b10000);
    for (int i = 0; i < MA; i++) begin
      tbl.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(8'h11 * (i + 1)));
      send(tbl[i]);
    end
    while (!loaded && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_nrst_len"}, last_nlow, 32'd2);
    chk({tag, "_done"}, {30'd0, loaded, busy}, 32'b10);
    chk({tag, "_bursts"}, wq_len.size(), MA);
    for (int i = 0; i < wq_len.size(); i++) begin
      chk({tag, "_hold_len"}, wq_len[i], SM + 1);
      chk({tag, "_byte"}, {24'd0, wq_dat[i]}, {24'd0, tbl[i]});
    end
    chk({tag, "_stable"}, {31'd0, unstable}, 32'd0);
  endtask

  task automatic set_freq(input logic [13:0] v);
    logic ok;
    ok = v >= 14'd1 && v <= 14'(MA);
    send(8'h02);
    send(v[7:0]);
    send({2'($urandom_range(0, 3)), v[13:8]});
    if (ok) exp_step = v;
    chk("freq_step", {18'd0, step}, {18'd0, exp_step});
    chk("freq_err", {31'd0, err}, {31'd0, !ok});
  endtask

  initial begin
    int n, k;
    logic [7:0] b;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset", {29'd0, rx_ready, nco_rst_n, busy}, 32'b110);
    send(8'h03);
    chk("run_unloaded", {30'd0, err, sys_en}, 32'b10);
    @(negedge clk);
    chk("err_pulse_end", {31'd0, err}, 32'd0);
    send(8'h00);
    chk("cmd_zero", {31'd0, err}, 32'd1);
    repeat (3) begin
      b = 8'($urandom_range(5, 255));
      send(b);
      chk("bad_cmd", {29'd0, err, busy, rx_ready}, 32'b101);
    end
    set_freq(14'd3);
    set_freq(14'd5);
    set_freq(14'd0);
    load(1'b0, "load1");
    chk("loaded_not_run", {31'd0, sys_en}, 32'd0);
    set_freq(14'(MA));
    set_freq(14'($urandom_range(MA + 1, 16383)));
    set_freq(14'd2);
    send(8'h03);
    chk("run", {30'd0, sys_en, err}, 32'b10);
    repeat (10) @(negedge clk);
    chk("run_hold", {17'd0, sys_en, step}, {17'd0, 1'b1, 14'd2});
    send(8'h04);
    chk("stop", {31'd0, sys_en}, 32'd0);
    send(8'h03);
    chk("rerun", {31'd0, sys_en}, 32'd1);
    load(1'b1, "load2");
    chk("run_cleared", {31'd0, sys_en}, 32'd0);
    send(8'h01);
    send(8'h5a);
    @(negedge clk);
    chk("in_hold", {21'd0, we, sys_en, busy, data}, {21'd0, 3'b111, 8'h5a});
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
`ifdef NCO_CTRL_TIMEOUT_EN
    @(negedge clk);
    send(8'h01);
    send(8'h11);
    n = 0;
    k = 0;
    while (!err && k < 200) begin
      if (rx_ready && busy) n++;
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_flags", {29'd0, err, busy, loaded}, 32'b100);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/nco_ctrl.md
NCO_CTRL -- requirements
Module: nco_ctrl

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 6000, giving the waveform table depth in bytes, identical to the controlled NCO.
REQ-002 SHALL have parameter STROBE_MAX, default 520, giving the NCO strobe terminal count, identical to the controlled NCO.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50_000_000, giving the maximum idle clk cycles between load bytes.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rx_valid_i, input, 1 bit: command/data byte valid.
REQ-007 SHALL have port rx_data_i, input, 8 bits: command/data byte.
REQ-008 SHALL have port rx_ready_o, output, 1 bit: byte accepted when both rx_valid_i and rx_ready_o are high.
REQ-009 SHALL have port nco_rst_n_o, output, 1 bit: NCO reset, active-low.
REQ-010 SHALL have port nco_sys_en_o, output, 1 bit: drives the NCO sys_en input.
REQ-011 SHALL have port nco_we_o, output, 1 bit: drives the NCO we_i input.
REQ-012 SHALL have port nco_data_o, output, 8 bits: drives the NCO data_i input.
REQ-013 SHALL have port nco_freq_step_o, output, 14 bits: drives the NCO freq_step_i input.
REQ-014 SHALL have port loaded_o, output, 1 bit: a complete table is resident.
REQ-015 SHALL have port busy_o, output, 1 bit: a load is in progress.
REQ-016 SHALL have port err_o, output, 1 bit: one-cycle error pulse.

Function
REQ-017 SHALL implement FSM states IDLE, FREQ_LO, FREQ_HI, NRST, LOAD_WAIT and LOAD_HOLD.
REQ-018 SHALL decode bytes accepted in IDLE as: 0x01 LOAD -> NRST; 0x02 SET_FREQ -> FREQ_LO; 0x03 RUN, which sets run flag if loaded_o is high, else pulses err_o; 0x04 STOP, which clears run flag; any other value pulses err_o and stays in IDLE.
REQ-019 SHALL, in FREQ_LO, accept the low byte; in FREQ_HI, accept the high byte with bits [7:6] ignored; the 14-bit value SHALL load nco_freq_step_o on the FREQ_HI accept if it is 1..MAX_ADDR, else the value SHALL be discarded and err_o pulsed; both paths return to IDLE.
REQ-020 SHALL drive nco_freq_step_o unchanged while running, and a new value SHALL take effect the cycle after the FREQ_HI accept.
REQ-021 SHALL, on entering NRST, clear the run flag and loaded_o, drive nco_rst_n_o low for exactly 2 cycles, clear the internal strobe mirror counter and byte counter, then go to LOAD_WAIT.
REQ-022 SHALL maintain a strobe mirror counter 0..STROBE_MAX that increments only while nco_sys_en_o is high and wraps to 0 after STROBE_MAX; the strobe SHALL be defined as counter==STROBE_MAX with nco_sys_en_o high.
REQ-023 SHALL, in LOAD_WAIT, hold nco_sys_en_o and nco_we_o low, and on a byte accept SHALL register the byte into nco_data_o and go to LOAD_HOLD.
REQ-024 SHALL, in LOAD_HOLD, hold nco_sys_en_o and nco_we_o high with nco_data_o stable for exactly STROBE_MAX+1 cycles, ending on the strobe cycle, then increment the byte counter.
REQ-025 SHALL, after the strobe, go to LOAD_WAIT if the byte counter is less than MAX_ADDR, else set loaded_o and go to IDLE.
REQ-026 SHALL drive rx_ready_o high in IDLE, FREQ_LO, FREQ_HI and LOAD_WAIT, and low in NRST and LOAD_HOLD.
REQ-027 SHALL treat every byte accepted during a load as table data; no command decode occurs during a load.
REQ-028 SHALL drive nco_sys_en_o in IDLE/FREQ_* as run flag AND loaded_o, and SHALL hold nco_we_o low outside LOAD_HOLD.
REQ-029 SHALL drive busy_o high in NRST, LOAD_WAIT and LOAD_HOLD.

Reset
REQ-030 SHALL, on rst_n low, immediately enter IDLE and clear the run flag, loaded_o, busy_o, err_o, nco_sys_en_o, nco_we_o, nco_data_o (0), nco_freq_step_o (1), rx_ready_o, strobe mirror counter and byte counter.
REQ-031 SHALL drive nco_rst_n_o low while rst_n is low, and SHALL release nco_rst_n_o synchronously to clk.

Configuration
REQ-032 SHALL, when NCO_CTRL_TIMEOUT_EN is defined, count idle cycles in LOAD_WAIT, and on reaching TIMEOUT_CYC SHALL abort to IDLE with loaded_o low and pulse err_o.
REQ-033 SHALL, when NCO_CTRL_TIMEOUT_EN is undefined, have no timeout counter and wait in LOAD_WAIT indefinitely.

Verification (MAX_ADDR=4, STROBE_MAX=3, TIMEOUT_CYC=20)
REQ-034 SHALL cover: bytes 0x01,0x11,0x22,0x33,0x44 -> nco_rst_n_o low 2 cycles; each data byte held with we=1 for 4 cycles; loaded_o=1; NCO table = 11,22,33,44.
REQ-035 SHALL cover: bytes 0x02,0x02,0x00 then 0x03 after a load -> nco_freq_step_o=2; nco_sys_en_o=1; NCO data_o cycles 11,33.
REQ-036 SHALL cover: 0x03 with no table loaded -> err_o pulse, nco_sys_en_o stays 0; 0x02,0x05,0x00 -> err_o pulse, nco_freq_step_o unchanged.
REQ-037 SHALL cover: 0x01 sent while running -> run flag cleared, nco_sys_en_o=0 during NRST; 0x04 issued mid-run -> nco_sys_en_o=0 next cycle.
REQ-038 SHALL cover: 0x01,0x11 then silence with timeout enabled -> err_o pulse 20 cycles into LOAD_WAIT, busy_o=0, loaded_o=0.
REQ-039 SHALL cover: rst_n asserted mid LOAD_HOLD -> all outputs at reset values asynchronously; busy_o=0.
